motor_pool_spike_counter: RTL
=============================

Name: motor_pool_spike_counter

Overview:
- Multi-channel, parametrised successor to the single-MN spike counter that feeds the muscle model.
- Counts time-multiplexed motoneuron spikes from a pool of NUM_MU units into ping-pong count banks.
- On each sim tick, sweeps the closed bank, applying a per-unit twitch gain (size-principle weighting), and publishes a weighted pool drive plus a raw total for the muscle stage.

Parameters:
- NUM_MU, 16, number of motor units (channels).
- IDX_W, 4, width of unit index; requires 2^IDX_W >= NUM_MU.
- CNT_W, 8, per-unit spike count width (saturating).
- GAIN_W, 8, per-unit twitch gain width, unsigned.
- SUM_W, 24, width of accumulated outputs (saturating).
- GAIN_RESET, 1, gain value loaded into every unit on reset.
- TAU_SHIFT, 3, decay shift for the optional activation filter.

Ports:
- neuron_clk, in, 1, the only clock.
- reset_sim, in, 1, asynchronous, active-low reset.
- spike_valid, in, 1, spike_idx/spike_in are valid this cycle.
- spike_idx, in, IDX_W, unit index of the current neuron slot.
- spike_in, in, 1, spike from unit spike_idx.
- sim_tick, in, 1, one-cycle frame-close strobe, synchronous to neuron_clk.
- gain_wr_en, in, 1, gain table write strobe.
- gain_wr_addr, in, IDX_W, gain table address.
- gain_wr_data, in, GAIN_W, gain value.
- busy, out, 1, high while SWEEP/PUBLISH is in progress.
- out_valid, out, 1, one-cycle pulse when outputs update.
- weighted_out, out, SUM_W, sum over units of cnt[k]*gain[k] for the last frame.
- raw_cnt_out, out, SUM_W, unweighted spike total for the last frame.
- act_out, out, SUM_W, activation value (see Optional Feature).
- sat_flag, out, 1, sticky per frame; some count or sum saturated.
- tick_overrun, out, 1, sticky until reset; a sim_tick arrived while busy.

Behaviour:
- Reset (reset_sim low, asynchronous): both banks cleared, gains = GAIN_RESET, active bank = 0, state ACCUM, all outputs 0. Reset mid-sweep aborts the sweep; no out_valid is produced.
- Spike counting runs in every state:
  - spike_valid && spike_in increments cnt[active][spike_idx], saturating at 2^CNT_W-1.
  - A saturating increment sets the frame's sat bit.
  - spike_idx >= NUM_MU is ignored.
- FSM states ACCUM -> SWEEP -> PUBLISH -> ACCUM.
- ACCUM + sim_tick:
  - Active bank toggles at that edge.
  - Closed bank = old active bank; sweep index k = 0; accumulators cleared; state -> SWEEP.
  - A spike in the same cycle as sim_tick lands in the closing (old) bank.
- SWEEP, one unit per cycle, k = 0..NUM_MU-1:
  - wacc += cnt[closed][k]*gain[k] and racc += cnt[closed][k], both saturating at 2^SUM_W-1; saturation sets the sat bit.
  - cnt[closed][k] is cleared in the same cycle.
  - After k = NUM_MU-1, state -> PUBLISH.
- PUBLISH (one cycle):
  - Register weighted_out, raw_cnt_out, act_out and sat_flag; out_valid = 1 for exactly this cycle.
  - Clear the frame sat bit; state -> ACCUM.
- Latency: sim_tick at cycle T gives out_valid at cycle T+NUM_MU+1. busy is high from T+1 through T+NUM_MU+1.
- sim_tick while busy: ignored (no bank swap), tick_overrun set; spikes keep accumulating in the current active bank, which merges into the next frame.
- Gain write: accepted in any state. If a write hits unit k in the same cycle the sweep reads unit k, the sweep uses the old gain; the new gain applies from the next frame.
- Outputs hold their values between out_valid pulses.

Optional Feature:
- MU_ACTIVATION_FILTER_EN defined: at PUBLISH, act_out <= act_out - (act_out >> TAU_SHIFT) + new weighted sum, saturating at 2^SUM_W-1. This is a first-order activation-state filter.
- Not defined: act_out <= weighted sum (identical to weighted_out); no filter register is built.

Test Plan:
- Reset, then 5 spikes on unit 3 (gain 1), then sim_tick -> out_valid at tick+17; weighted_out=5, raw_cnt_out=5, sat_flag=0.
- Set gain[2]=10, gain[7]=4; inject 3 spikes on unit 2 and 2 on unit 7; tick -> weighted_out=38, raw_cnt_out=5.
- 300 spikes on unit 0 within one frame (CNT_W=8) -> raw_cnt_out=255, sat_flag=1; the next empty frame gives 0 with sat_flag=0.
- Spike on unit 1 in the tick cycle plus 2 more spikes on unit 1 during SWEEP -> frame N raw=1, frame N+1 raw=2. Second tick 5 cycles after the first -> tick_overrun=1, no extra out_valid.
- Assert reset_sim low at sweep cycle 8 -> no out_valid; all outputs 0; a following frame with 4 spikes reports 4.
- With MU_ACTIVATION_FILTER_EN and TAU_SHIFT=3, weighted sum 80 for three frames -> act_out = 80, 150, 212.

Source files
------------

// File: rtl/motor_pool_spike_counter_if.sv
// Spike, gain-write and pool-output bundle of motor_pool_spike_counter.
// master = spike/gain source, slave = the counter itself.
interface motor_pool_spike_counter_if #(
    parameter int IDX_W  = 4,
    parameter int GAIN_W = 8,
    parameter int SUM_W  = 24
);
    logic              spike_valid;
    logic [IDX_W-1:0]  spike_idx;
    logic              spike_in;
    logic              sim_tick;
    logic              gain_wr_en;
    logic [IDX_W-1:0]  gain_wr_addr;
    logic [GAIN_W-1:0] gain_wr_data;
    logic              busy;
    logic              out_valid;
    logic [SUM_W-1:0]  weighted_out;
    logic [SUM_W-1:0]  raw_cnt_out;
    logic [SUM_W-1:0]  act_out;
    logic              sat_flag;
    logic              tick_overrun;

    modport master (
        output spike_valid, spike_idx, spike_in, sim_tick,
        output gain_wr_en, gain_wr_addr, gain_wr_data,
        input  busy, out_valid, weighted_out, raw_cnt_out,
        input  act_out, sat_flag, tick_overrun
    );

    modport slave (
        input  spike_valid, spike_idx, spike_in, sim_tick,
        input  gain_wr_en, gain_wr_addr, gain_wr_data,
        output busy, out_valid, weighted_out, raw_cnt_out,
        output act_out, sat_flag, tick_overrun
    );
endinterface

// File: rtl/motor_pool_spike_counter.sv
// Motor-pool spike counter: ping-pong per-unit spike banks, gain-weighted
// sweep per sim tick. Optional macro MU_ACTIVATION_FILTER_EN adds act filter.
module motor_pool_spike_counter #(
    parameter int NUM_MU     = 16,
    parameter int IDX_W      = 4,
    parameter int CNT_W      = 8,
    parameter int GAIN_W     = 8,
    parameter int SUM_W      = 24,
    parameter int GAIN_RESET = 1
`ifdef MU_ACTIVATION_FILTER_EN
    ,
    parameter int TAU_SHIFT  = 3
`endif
) (
    input logic                       neuron_clk,
    input logic                       reset_sim,
    motor_pool_spike_counter_if.slave bus
);
    localparam int PROD_W = CNT_W + GAIN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;
    localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(NUM_MU - 1);

    typedef enum logic [1:0] {ACCUM, SWEEP, PUBLISH} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt [2][NUM_MU];
    logic [GAIN_W-1:0] r_gain [NUM_MU];
    logic              r_active;
    logic [1:0]        r_bsat;
    logic              r_ssat;
    logic [IDX_W-1:0]  r_k;
    logic [SUM_W-1:0]  r_wacc;
    logic [SUM_W-1:0]  r_racc;
    logic [SUM_W-1:0]  r_wout;
    logic [SUM_W-1:0]  r_rout;
    logic              r_sat_out;
    logic              r_overrun;

    logic              w_closed;
    logic              w_busy;
    logic              w_valid;
    logic              w_tick_acc;
    logic              w_sweep;
    logic              w_last;
    logic              w_idx_ok;
    logic              w_spk;
    logic [CNT_W-1:0]  w_cur;
    logic [CNT_W-1:0]  w_sweep_cnt;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W:0]    w_wsum;
    logic [SUM_W:0]    w_rsum;
    logic              w_wovf;
    logic              w_rovf;
    logic [SUM_W-1:0]  w_wnext;
    logic [SUM_W-1:0]  w_rnext;

    if (NUM_MU < (1 << IDX_W)) begin : g_idx_chk
        assign w_idx_ok = bus.spike_idx < IDX_W'(NUM_MU);
    end else begin : g_idx_all
        assign w_idx_ok = 1'b1;
    end

    assign w_closed    = ~r_active;
    assign w_tick_acc  = (r_state == ACCUM) && bus.sim_tick;
    assign w_sweep     = (r_state == SWEEP);
    assign w_last      = w_sweep && (r_k == K_LAST);
    assign w_spk       = bus.spike_valid && bus.spike_in && w_idx_ok;
    assign w_cur       = r_cnt[r_active][bus.spike_idx];
    assign w_sweep_cnt = r_cnt[w_closed][r_k];
    assign w_prod      = PROD_W'(w_sweep_cnt) * PROD_W'(r_gain[r_k]);
    assign w_wsum      = (SUM_W+1)'(r_wacc) + (SUM_W+1)'(w_prod);
    assign w_rsum      = (SUM_W+1)'(r_racc) + (SUM_W+1)'(w_sweep_cnt);
    assign w_wovf      = w_wsum[SUM_W];
    assign w_rovf      = w_rsum[SUM_W];
    assign w_wnext     = w_wovf ? SUM_MAX : w_wsum[SUM_W-1:0];
    assign w_rnext     = w_rovf ? SUM_MAX : w_rsum[SUM_W-1:0];

    // Frame state register.
    always_ff @(posedge neuron_clk or negedge reset_sim) begin
        if (!reset_sim) r_state <= ACCUM;
        else            r_state <= w_state_nxt;
    end

    // Next state, busy and the one-cycle publish strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        unique case (r_state)
            ACCUM: begin
                if (bus.sim_tick) w_state_nxt = SWEEP;
            end
            SWEEP: begin
                w_busy = 1'b1;
                if (r_k == K_LAST) w_state_nxt = PUBLISH;
            end
            PUBLISH: begin
                w_busy      = 1'b1;
                w_valid     = 1'b1;
                w_state_nxt = ACCUM;
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Spike counting into the active bank; sweep clears the closed bank.
    always_ff @(posedge neuron_clk or negedge reset_sim) begin
        if (!reset_sim) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < NUM_MU; k++)
                    r_cnt[b][k] <= '0;
            r_bsat <= '0;
        end else begin
            if (w_sweep) r_cnt[w_closed][r_k] <= '0;
            if (w_last)  r_bsat[w_closed] <= 1'b0;
            if (w_spk) begin
                if (w_cur == CNT_MAX) r_bsat[r_active] <= 1'b1;
                else r_cnt[r_active][bus.spike_idx] <= w_cur + 1'b1;
            end
        end
    end

    // Gain table; a write during the sweep only lands after the read.
    always_ff @(posedge neuron_clk or negedge reset_sim) begin
        if (!reset_sim) begin
            for (int k = 0; k < NUM_MU; k++)
                r_gain[k] <= GAIN_W'(GAIN_RESET);
        end else if (bus.gain_wr_en) begin
            r_gain[bus.gain_wr_addr] <= bus.gain_wr_data;
        end
    end

    // Bank swap on tick, then one unit per cycle into the accumulators.
    always_ff @(posedge neuron_clk or negedge reset_sim) begin
        if (!reset_sim) begin
            r_active <= 1'b0;
            r_k      <= '0;
            r_wacc   <= '0;
            r_racc   <= '0;
            r_ssat   <= 1'b0;
        end else if (w_tick_acc) begin
            r_active <= ~r_active;
            r_k      <= '0;
            r_wacc   <= '0;
            r_racc   <= '0;
            r_ssat   <= 1'b0;
        end else if (w_sweep) begin
            r_k    <= r_k + 1'b1;
            r_wacc <= w_wnext;
            r_racc <= w_rnext;
            r_ssat <= r_ssat | w_wovf | w_rovf;
        end
    end

    // Published totals land with the last unit so they meet out_valid.
    always_ff @(posedge neuron_clk or negedge reset_sim) begin
        if (!reset_sim) begin
            r_wout    <= '0;
            r_rout    <= '0;
            r_sat_out <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_last) begin
                r_wout    <= w_wnext;
                r_rout    <= w_rnext;
                r_sat_out <= r_bsat[w_closed] | r_ssat | w_wovf | w_rovf;
            end
            if (bus.sim_tick && r_state != ACCUM) r_overrun <= 1'b1;
        end
    end

`ifdef MU_ACTIVATION_FILTER_EN
    logic [SUM_W-1:0] r_act;
    logic [SUM_W-1:0] w_adecay;
    logic [SUM_W:0]   w_asum;

    assign w_adecay = r_act - (r_act >> TAU_SHIFT);
    assign w_asum   = (SUM_W+1)'(w_adecay) + (SUM_W+1)'(w_wnext);

    // First-order leaky activation, updated once per published frame.
    always_ff @(posedge neuron_clk or negedge reset_sim) begin
        if (!reset_sim)  r_act <= '0;
        else if (w_last) r_act <= w_asum[SUM_W] ? SUM_MAX : w_asum[SUM_W-1:0];
    end

    assign bus.act_out = r_act;
`else
    assign bus.act_out = r_wout;
`endif

    assign bus.busy         = w_busy;
    assign bus.out_valid    = w_valid;
    assign bus.weighted_out = r_wout;
    assign bus.raw_cnt_out  = r_rout;
    assign bus.sat_flag     = r_sat_out;
    assign bus.tick_overrun = r_overrun;
endmodule
